mips_pipe_ctrl: RTL and testbench

Pipelined control and hazard block for the 5-stage MIPS core. It decodes the ID-stage opcode into WB/MEM/EX control bundles and carries them through internal ID/EX, EX/MEM and MEM/WB control registers. It also tracks destination and source register numbers, detects load-use hazards and inserts bubbles, generates EX-stage forwarding selects, and resolves branch and jump redirects with flushes. It replaces the purely combinational decoder and sits beside the datapath pipeline registers, which it drives with stall and flush.

---
 rtl/mips_ctrl_pkg.sv | 25 ++
 rtl/mips_ctrl_decode.sv | 68 ++++++
 rtl/mips_pipe_ctrl.sv | 153 +++++++++++++++
 tb/tb_mips_pipe_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the pipelined MIPS control path: opcodes, ALUOp codes,
// control-bundle widths and forwarding selects.
package mips_ctrl_pkg;

    localparam int WB_W  = 2;   // {RegWrite, MemToReg}
    localparam int MEM_W = 3;   // {Branch, MemRead, MemWrite}
    localparam int EX_W  = 4;   // {RegDst, ALUOp[1:0], ALUSrc}

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode decoder producing the WB/MEM/EX control bundles.
// Unknown or disabled opcodes decode to an all-zero bubble and raise illegal.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
#(
    parameter bit EN_EXT = 1'b1
) (
    input  logic [5:0]       opcode,
    output logic [WB_W-1:0]  wb,
    output logic [MEM_W-1:0] mem,
    output logic [EX_W-1:0]  ex,
    output logic             ne,
    output logic             is_jump,
    output logic             illegal
);

    always_comb begin
        wb      = '0;
        mem     = '0;
        ex      = '0;
        ne      = 1'b0;
        is_jump = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ex = {1'b1, ALUOP_FUNC, 1'b0};
                wb = 2'b10;
            end
            OP_LW: begin
                ex  = {1'b0, ALUOP_ADD, 1'b1};
                mem = 3'b010;
                wb  = 2'b11;
            end
            OP_SW: begin
                ex  = {1'b0, ALUOP_ADD, 1'b1};
                mem = 3'b001;
            end
            OP_BEQ: begin
                ex  = {1'b0, ALUOP_SUB, 1'b0};
                mem = 3'b100;
            end
            OP_BNE: begin
                if (EN_EXT) begin
                    ex  = {1'b0, ALUOP_SUB, 1'b0};
                    mem = 3'b100;
                    ne  = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_ADDI: begin
                if (EN_EXT) begin
                    ex = {1'b0, ALUOP_ADD, 1'b1};
                    wb = 2'b10;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_J: begin
                // The jump itself travels down the pipe as a bubble.
                if (EN_EXT) is_jump = 1'b1;
                else        illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Pipelined control and hazard unit: carries decoded control through ID/EX,
// EX/MEM and MEM/WB, and generates stall, flush, branch/jump and forwarding.
module mips_pipe_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit EN_EXT = 1'b1,
    parameter int RA_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             ex_zero,
    output logic [EX_W-1:0]  ex_ctrl,
    output logic [MEM_W-1:0] mem_ctrl,
    output logic [WB_W-1:0]  wb_ctrl,
    output logic [RA_W-1:0]  wb_dst,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic             if_flush,
    output logic             pc_src,
    output logic             jump,
    output logic             illegal_op
);

    logic [WB_W-1:0]  dec_wb;
    logic [MEM_W-1:0] dec_mem;
    logic [EX_W-1:0]  dec_ex;
    logic             dec_ne;
    logic             dec_is_jump;
    logic             dec_illegal;

    mips_ctrl_decode #(.EN_EXT(EN_EXT)) u_decode (
        .opcode  (id_opcode),
        .wb      (dec_wb),
        .mem     (dec_mem),
        .ex      (dec_ex),
        .ne      (dec_ne),
        .is_jump (dec_is_jump),
        .illegal (dec_illegal)
    );

    // ID/EX, EX/MEM and MEM/WB state
    logic [WB_W-1:0]  ex_wb_reg, ex_wb_next, mem_wb_reg, wb_wb_reg;
    logic [MEM_W-1:0] ex_mem_reg, ex_mem_next, mem_mem_reg;
    logic [EX_W-1:0]  ex_ex_reg, ex_ex_next;
    logic             ex_ne_reg, ex_ne_next, mem_ne_reg, mem_zero_reg;
    logic [RA_W-1:0]  ex_rs_reg, ex_rs_next, ex_rt_reg, ex_rt_next;
    logic [RA_W-1:0]  ex_dst_reg, ex_dst_next, mem_dst_reg, wb_dst_reg;
    logic             illegal_reg;

    logic [RA_W-1:0]  id_dst;
    logic [WB_W-1:0]  id_wb;

    assign id_dst = dec_ex[3] ? id_rd : id_rt;
    // Writes to register 0 are dropped here so forwarding never matches $0.
    assign id_wb  = {dec_wb[1] & (id_dst != '0), dec_wb[0]};

    assign pc_src   = mem_mem_reg[2] & (mem_zero_reg ^ mem_ne_reg);
    assign stall    = id_valid & ex_mem_reg[1] & (ex_dst_reg != '0) &
                      ((ex_dst_reg == id_rs) | (ex_dst_reg == id_rt)) & ~pc_src;
    assign jump     = dec_is_jump & id_valid & ~stall & ~pc_src;
    assign if_flush = pc_src | jump;

    always_comb begin
        ex_wb_next  = '0;
        ex_mem_next = '0;
        ex_ex_next  = '0;
        ex_ne_next  = 1'b0;
        ex_rs_next  = '0;
        ex_rt_next  = '0;
        ex_dst_next = '0;
        if (id_valid && !stall && !pc_src) begin
            ex_wb_next  = id_wb;
            ex_mem_next = dec_mem;
            ex_ex_next  = dec_ex;
            ex_ne_next  = dec_ne;
            ex_rs_next  = id_rs;
            ex_rt_next  = id_rt;
            ex_dst_next = id_dst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_wb_reg    <= '0;
            ex_mem_reg   <= '0;
            ex_ex_reg    <= '0;
            ex_ne_reg    <= 1'b0;
            ex_rs_reg    <= '0;
            ex_rt_reg    <= '0;
            ex_dst_reg   <= '0;
            mem_wb_reg   <= '0;
            mem_mem_reg  <= '0;
            mem_ne_reg   <= 1'b0;
            mem_zero_reg <= 1'b0;
            mem_dst_reg  <= '0;
            wb_wb_reg    <= '0;
            wb_dst_reg   <= '0;
            illegal_reg  <= 1'b0;
        end else begin
            ex_wb_reg  <= ex_wb_next;
            ex_mem_reg <= ex_mem_next;
            ex_ex_reg  <= ex_ex_next;
            ex_ne_reg  <= ex_ne_next;
            ex_rs_reg  <= ex_rs_next;
            ex_rt_reg  <= ex_rt_next;
            ex_dst_reg <= ex_dst_next;
            if (pc_src) begin
                mem_wb_reg   <= '0;
                mem_mem_reg  <= '0;
                mem_ne_reg   <= 1'b0;
                mem_zero_reg <= 1'b0;
                mem_dst_reg  <= '0;
            end else begin
                mem_wb_reg   <= ex_wb_reg;
                mem_mem_reg  <= ex_mem_reg;
                mem_ne_reg   <= ex_ne_reg;
                mem_zero_reg <= ex_zero;
                mem_dst_reg  <= ex_dst_reg;
            end
            wb_wb_reg  <= mem_wb_reg;
            wb_dst_reg <= mem_dst_reg;
            if (id_valid && dec_illegal) illegal_reg <= 1'b1;
        end
    end

    // Operand 0 compares against rs, operand 1 against rt; EX/MEM wins over MEM/WB.
    logic [1:0][RA_W-1:0] ex_src;
    logic [1:0][1:0]      fwd_sel;

    assign ex_src = {ex_rt_reg, ex_rs_reg};

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign fwd_sel[gi] =
            (mem_wb_reg[1] && (mem_dst_reg != '0) && (mem_dst_reg == ex_src[gi])) ? FWD_EXMEM :
            (wb_wb_reg[1]  && (wb_dst_reg  != '0) && (wb_dst_reg  == ex_src[gi])) ? FWD_MEMWB :
                                                                                   FWD_RF;
    end

    assign fwd_a      = fwd_sel[0];
    assign fwd_b      = fwd_sel[1];
    assign ex_ctrl    = ex_ex_reg;
    assign mem_ctrl   = mem_mem_reg;
    assign wb_ctrl    = wb_wb_reg;
    assign wb_dst     = wb_dst_reg;
    assign illegal_op = illegal_reg;

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Directed bench for mips_pipe_ctrl: one full-featured instance and one with
// the extended opcodes disabled, both driven by the same ID-stage stimulus.
module tb_mips_pipe_ctrl;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_BAD   = 6'h3F;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_zero;

    logic [3:0] ex_ctrl, ex_ctrl_b;
    logic [2:0] mem_ctrl, mem_ctrl_b;
    logic [1:0] wb_ctrl, wb_ctrl_b;
    logic [4:0] wb_dst, wb_dst_b;
    logic [1:0] fwd_a, fwd_b, fwd_a_b, fwd_b_b;
    logic       stall, if_flush, pc_src, jump, illegal_op;
    logic       stall_b, if_flush_b, pc_src_b, jump_b, illegal_op_b;

    int checks;
    int failures;

    mips_pipe_ctrl #(.EN_EXT(1'b1), .RA_W(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .wb_dst(wb_dst),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .if_flush(if_flush),
        .pc_src(pc_src), .jump(jump), .illegal_op(illegal_op)
    );

    mips_pipe_ctrl #(.EN_EXT(1'b0), .RA_W(5)) u_dut_base (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_ctrl(ex_ctrl_b), .mem_ctrl(mem_ctrl_b), .wb_ctrl(wb_ctrl_b), .wb_dst(wb_dst_b),
        .fwd_a(fwd_a_b), .fwd_b(fwd_b_b), .stall(stall_b), .if_flush(if_flush_b),
        .pc_src(pc_src_b), .jump(jump_b), .illegal_op(illegal_op_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one instruction (or a bubble) in ID for the current cycle.
    task automatic put(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic z);
        id_valid  = v;
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        ex_zero   = z;
        #1;
        $display("t=%0t issue v=%0b op=%02h rs=%0d rt=%0d rd=%0d ex_zero=%0b",
                 $time, v, op, rs, rt, rd, z);
    endtask

    task automatic idle();
        put(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle();
        tick();
        tick();
        check("rst_ex_ctrl", ex_ctrl, 4'b0000);
        check("rst_wb_ctrl", wb_ctrl, 2'b00);
        check("rst_stall", stall, 1'b0);
        check("rst_illegal", illegal_op, 1'b0);
        rst_n = 1'b1;

        // lw latency through the three control registers
        put(1'b1, OP_LW, 5'd0, 5'd2, 5'd0, 1'b0);
        tick(); idle();
        check("lw_ex_ctrl", ex_ctrl, 4'b0001);
        tick();
        check("lw_mem_ctrl", mem_ctrl, 3'b010);
        tick();
        check("lw_wb_ctrl", wb_ctrl, 2'b11);
        check("lw_wb_dst", wb_dst, 5'd2);

        // reset asserted with a load in flight
        put(1'b1, OP_LW, 5'd0, 5'd9, 5'd0, 1'b0);
        tick(); idle();
        check("mid_ex_before", ex_ctrl, 4'b0001);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ex_ctrl", ex_ctrl, 4'b0000);
        check("mid_rst_mem_ctrl", mem_ctrl, 3'b000);
        check("mid_rst_wb_ctrl", wb_ctrl, 2'b00);
        check("mid_rst_wb_dst", wb_dst, 5'd0);
        tick();
        check("mid_rst_mem_hold", mem_ctrl, 3'b000);
        rst_n = 1'b1;
        tick();

        // load-use: lw $2 then add $3,$2,$4
        put(1'b1, OP_LW, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        put(1'b1, OP_RTYPE, 5'd2, 5'd4, 5'd3, 1'b0);
        check("lu_stall_on", stall, 1'b1);
        tick();
        check("lu_stall_off", stall, 1'b0);
        check("lu_bubble_ex", ex_ctrl, 4'b0000);
        tick(); idle();
        check("lu_add_ex", ex_ctrl, 4'b1100);
        check("lu_fwd_a", fwd_a, 2'b01);
        check("lu_fwd_b", fwd_b, 2'b00);
        tick(); tick();

        // forwarding priority: add $5, sub $5, or $6,$5,$5
        put(1'b1, OP_RTYPE, 5'd1, 5'd1, 5'd5, 1'b0);
        tick();
        put(1'b1, OP_RTYPE, 5'd2, 5'd2, 5'd5, 1'b0);
        tick();
        put(1'b1, OP_RTYPE, 5'd5, 5'd5, 5'd6, 1'b0);
        check("fp_no_stall", stall, 1'b0);
        tick(); idle();
        check("fp_fwd_a", fwd_a, 2'b10);
        check("fp_fwd_b", fwd_b, 2'b10);
        tick(); tick(); tick();

        // $0 destination never forwards and never writes back
        put(1'b1, OP_RTYPE, 5'd1, 5'd1, 5'd0, 1'b0);
        tick();
        put(1'b1, OP_RTYPE, 5'd0, 5'd0, 5'd7, 1'b0);
        tick(); idle();
        check("z0_fwd_a", fwd_a, 2'b00);
        check("z0_fwd_b", fwd_b, 2'b00);
        tick();
        check("z0_wb_ctrl", wb_ctrl, 2'b00);
        tick(); tick(); tick();

        // taken beq: two younger instructions squashed here, third by IF/ID flush
        put(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        put(1'b1, OP_RTYPE, 5'd1, 5'd1, 5'd10, 1'b1);
        check("beq_pc_src_ex", pc_src, 1'b0);
        tick();
        put(1'b1, OP_RTYPE, 5'd1, 5'd1, 5'd11, 1'b0);
        check("beq_pc_src", pc_src, 1'b1);
        check("beq_if_flush", if_flush, 1'b1);
        tick(); idle();
        check("beq_pc_src_once", pc_src, 1'b0);
        check("beq_sq_ex", ex_ctrl, 4'b0000);
        check("beq_sq_mem", mem_ctrl, 3'b000);
        tick();
        check("beq_sq_wb1", wb_ctrl, 2'b00);
        tick();
        check("beq_sq_wb2", wb_ctrl, 2'b00);
        tick();
        check("beq_sq_wb3", wb_ctrl, 2'b00);

        // bne: zero=1 not taken, zero=0 taken
        put(1'b1, OP_BNE, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        put(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0, 1'b1);
        tick(); idle();
        check("bne_eq_pc_src", pc_src, 1'b0);
        put(1'b1, OP_BNE, 5'd1, 5'd2, 5'd0, 1'b0);
        tick(); idle();
        tick();
        check("bne_ne_pc_src", pc_src, 1'b1);
        check("bne_base_pc_src", pc_src_b, 1'b0);
        tick(); tick();

        // jump, and the restricted decoder
        put(1'b1, OP_J, 5'd0, 5'd0, 5'd0, 1'b0);
        check("j_jump", jump, 1'b1);
        check("j_if_flush", if_flush, 1'b1);
        check("j_base_jump", jump_b, 1'b0);
        tick(); idle();
        check("j_jump_once", jump, 1'b0);
        check("j_bubble_ex", ex_ctrl, 4'b0000);
        check("j_base_illegal", illegal_op_b, 1'b1);
        check("j_ext_legal", illegal_op, 1'b0);
        put(1'b1, OP_ADDI, 5'd1, 5'd3, 5'd0, 1'b0);
        tick(); idle();
        check("addi_ex", ex_ctrl, 4'b0001);
        check("addi_base_ex", ex_ctrl_b, 4'b0000);
        put(1'b1, OP_BAD, 5'd0, 5'd0, 5'd0, 1'b0);
        tick(); idle();
        check("bad_illegal", illegal_op, 1'b1);
        check("bad_ex", ex_ctrl, 4'b0000);
        tick(); tick(); tick();
        check("illegal_sticky", illegal_op_b, 1'b1);

        // load-use stall coinciding with a taken branch
        put(1'b1, OP_BEQ, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        put(1'b1, OP_LW, 5'd1, 5'd7, 5'd0, 1'b1);
        tick();
        put(1'b1, OP_RTYPE, 5'd7, 5'd1, 5'd8, 1'b0);
        check("sim_stall", stall, 1'b0);
        check("sim_pc_src", pc_src, 1'b1);
        check("sim_if_flush", if_flush, 1'b1);
        tick(); idle();
        check("sim_sq_ex", ex_ctrl, 4'b0000);
        check("sim_sq_mem", mem_ctrl, 3'b000);
        tick();

        // only reset clears the sticky flag
        rst_n = 1'b0;
        #1;
        check("final_rst_illegal", illegal_op, 1'b0);
        check("final_rst_illegal_b", illegal_op_b, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
